// File: rtl/reg_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arb_pkg
// Description : Shared types, constants and helpers for the reg_share_arb
//               round-robin arbiter / shared-register write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_share_arb_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Guard counter width; covers guard intervals 0..15
    localparam int GUARD_CW = 4;

    // Ceiling log2, evaluated at elaboration time for index widths
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Index width that never collapses to zero bits
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage : reg_share_arb_pkg
`default_nettype wire

// File: rtl/rr_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pick
// Description : Combinational round-robin pick. Returns the first set request
//               bit scanning ptr, ptr+1, ... wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_pick
    import reg_share_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          found_o
);

    logic [IW-1:0] w_win_hi;
    logic          w_found_hi;
    logic [IW-1:0] w_win_lo;
    logic          w_found_lo;

    // Lowest set bit at or above ptr wins; otherwise wrap to lowest set bit
    always_comb begin
        w_win_hi   = '0;
        w_found_hi = 1'b0;
        w_win_lo   = '0;
        w_found_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && (IW'(i) >= ptr_i) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_win_hi   = IW'(i);
            end
            if (req_i[i] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = IW'(i);
            end
        end
        found_o  = w_found_hi | w_found_lo;
        winner_o = w_found_hi ? w_win_hi : w_win_lo;
    end

endmodule : rr_arb_pick
`default_nettype wire

// File: rtl/reg_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arb
// Description : Round-robin arbiter and write sequencer sharing one W-bit
//               register among N requesters, with a configurable guard
//               interval after each write.
//               Optional macro REG_ARB_PRIO0_EN: requester 0 becomes fixed
//               highest priority; requesters 1..N-1 stay round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int GUARD = 2,
    localparam int IW    = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst,      // asynchronous, active-low
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_vld,
    output logic [IW-1:0]  owner,
    output logic           busy
);

    localparam logic [GUARD_CW-1:0] GUARD_LOAD = GUARD_CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0]       LAST_IDX   = IW'(N - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         win_q, win_d;
    logic [N-1:0]          gnt_q, gnt_d;
    logic [W-1:0]          q_q, q_d;
    logic                  vld_q, vld_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [GUARD_CW-1:0]   gcnt_q, gcnt_d;

    logic [W-1:0]          w_lane [N];
    logic [N-1:0]          w_pick_req;
    logic                  w_prio0;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_pick_found;

    // Unpack the flat data bus into per-requester lanes
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_lane[i] = wdata[i*W +: W];
    end

`ifdef REG_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; the picker only sees 1..N-1
    assign w_pick_req = {req[N-1:1], 1'b0};
    assign w_prio0    = req[0];
`else
    assign w_pick_req = req;
    assign w_prio0    = 1'b0;
`endif

    rr_arb_pick #(
        .N (N)
    ) u_pick (
        .req_i    (w_pick_req),
        .ptr_i    (ptr_q),
        .winner_o (w_pick_idx),
        .found_o  (w_pick_found)
    );

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            vld_q   <= 1'b0;
            owner_q <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
            owner_q <= owner_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, write on GRANT exit, count out GUARD
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = '0;
        q_d     = q_q;
        vld_d   = vld_q;
        owner_d = owner_q;
        gcnt_d  = gcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_prio0) begin
                    // Fixed-priority win leaves the rotation untouched
                    win_d    = '0;
                    gnt_d[0] = 1'b1;
                    state_d  = ST_GRANT;
                end else if (w_pick_found) begin
                    win_d             = w_pick_idx;
                    gnt_d[w_pick_idx] = 1'b1;
                    ptr_d             = (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
                    state_d           = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Write happens regardless of whether the winner still requests
                q_d     = w_lane[win_q];
                owner_d = win_q;
                vld_d   = 1'b1;
                if (GUARD > 0) begin
                    gcnt_d  = GUARD_LOAD;
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GUARD: begin
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign q_vld = vld_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_GRANT) || (state_q == ST_GUARD);

endmodule : reg_share_arb
`default_nettype wire

// File: tb/tb_reg_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_share_arb
// Description : Directed self-checking bench for reg_share_arb. One instance
//               with no guard interval, one with a two-cycle guard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req0, req2;
    logic [31:0] wdata0, wdata2;

    logic [3:0]  gnt0, gnt2;
    logic [7:0]  q0, q2;
    logic        vld0, vld2;
    logic [1:0]  owner0, owner2;
    logic        busy0, busy2;

    int errors = 0;
    int checks = 0;
    int ord [3];

    always #5 clk = ~clk;

    reg_share_arb #(.N(4), .W(8), .GUARD(0)) u_g0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .wdata (wdata0),
        .gnt   (gnt0),
        .q     (q0),
        .q_vld (vld0),
        .owner (owner0),
        .busy  (busy0)
    );

    reg_share_arb #(.N(4), .W(8), .GUARD(2)) u_g2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .wdata (wdata2),
        .gnt   (gnt2),
        .q     (q2),
        .q_vld (vld2),
        .owner (owner2),
        .busy  (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        req0   = 4'b0000;
        req2   = 4'b0000;
        wdata0 = {8'h77, 8'h3C, 8'hA5, 8'h11};
        wdata2 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();

        // Reset state
        check("rst_gnt",   gnt0,   4'b0000);
        check("rst_q",     q0,     8'h00);
        check("rst_vld",   vld0,   1'b0);
        check("rst_owner", owner0, 2'd0);
        check("rst_busy",  busy0,  1'b0);
        check("rst_busy2", busy2,  1'b0);
        rst = 1'b1;

        // Single request, no guard
        req0 = 4'b0100;
        tick();
        check("s_gnt",  gnt0,  4'b0100);
        check("s_busy", busy0, 1'b1);
        check("s_vld0", vld0,  1'b0);
        req0 = 4'b0000;
        tick();
        check("s_gnt_off", gnt0,   4'b0000);
        check("s_q",       q0,     8'h3C);
        check("s_owner",   owner0, 2'd2);
        check("s_vld1",    vld0,   1'b1);
        check("s_idle",    busy0,  1'b0);

        // All requesting, guard of two: order 0..3, grants four cycles apart
        req2 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("all_gnt",  gnt2,  32'(4'b0001 << k));
            check("all_busy", busy2, 1'b1);
            req2 = req2 & ~(4'b0001 << k);
            tick();
            check("all_gnt_off", gnt2,   4'b0000);
            check("all_q",       q2,     32'(8'hA0 + k));
            check("all_owner",   owner2, k);
            check("all_busy_g1", busy2,  1'b1);
            tick();
            check("all_busy_g2", busy2, 1'b1);
            check("all_gnt_g2",  gnt2,  4'b0000);
            tick();
            check("all_idle", busy2, 1'b0);
        end

        // Wrap: pointer returned to 0 after requester 3
        req2 = 4'b1001;
        tick();
        check("wrap_gnt0", gnt2, 4'b0001);
        req2 = 4'b1000;
        tick();
        check("wrap_q0", q2, 8'hA0);
        tick();
        tick();
        tick();
        check("wrap_gnt3", gnt2, 4'b1000);
        req2 = 4'b0000;
        tick();
        check("wrap_q3",     q2,     8'hA3);
        check("wrap_owner3", owner2, 2'd3);

        // Simultaneous requests, no guard; pointer sits at 3
`ifdef REG_ARB_PRIO0_EN
        ord = '{0, 3, 1};
`else
        ord = '{3, 0, 1};
`endif
        req0 = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rr_gnt", gnt0, 32'(4'b0001 << ord[k]));
            req0 = req0 & ~(4'b0001 << ord[k]);
            tick();
            check("rr_q",     q0,     (wdata0 >> (8 * ord[k])) & 32'hFF);
            check("rr_owner", owner0, ord[k]);
        end
        check("pre_rst_q", q0, 8'hA5);

        // Reset mid-GRANT: pointer at 2, so 0010 resolves to requester 1
        req0 = 4'b0010;
        tick();
        check("mg_gnt", gnt0, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        check("mg_async_gnt",  gnt0,  4'b0000);
        check("mg_async_q",    q0,    8'h00);
        check("mg_async_vld",  vld0,  1'b0);
        check("mg_async_busy", busy0, 1'b0);
        tick();
        check("mg_hold_q", q0, 8'h00);
        rst  = 1'b1;
        // Pointer back at 0: 1010 gives requester 1 (pointer 2 would give 3)
        req0 = 4'b1010;
        tick();
        check("post_gnt", gnt0, 4'b0010);
        check("post_q",   q0,   8'h00);
        req0 = 4'b1000;
        tick();
        check("post_wq",    q0,     8'hA5);
        check("post_owner", owner0, 2'd1);
        req0 = 4'b0000;

`ifdef REG_ARB_PRIO0_EN
        // Requester 0 wins every arbitration while held; pointer stays at 2
        req0 = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("p0_gnt", gnt0, 4'b0001);
            tick();
            check("p0_q", q0, 8'h11);
        end
        req0 = 4'b0110;
        ord  = '{2, 1, 2};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("p12_gnt", gnt0, 32'(4'b0001 << ord[k]));
            if (k == 2) req0 = 4'b0000;
            tick();
            check("p12_owner", owner0, ord[k]);
        end
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_share_arb
`default_nettype wire
